// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared FSM state codes and default tick constants
// Purpose: state encodings of the emergency request conditioner (also used by
//          the traffic light controller's debug muxing) and default timing.
// Ports:   none (package).
package traffic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DEBOUNCE = 3'd1;
  localparam state_t ST_ACTIVE   = 3'd2;
  localparam state_t ST_HOLD     = 3'd3;
  localparam state_t ST_COOLDOWN = 3'd4;

  localparam int DEF_TICK_DIV       = 1000000;
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_HOLD_TICKS     = 10;
  localparam int DEF_COOLDOWN_TICKS = 20;
  localparam int DEF_TIMEOUT_TICKS  = 200;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running clk divider producing a one-clk tick
// Purpose: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
// Ports:   clk   - system clock
//          reset - asynchronous, active-high
//          tick  - one-clk pulse every TICK_DIV clks
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] count;

  assign tick = (count == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/emergency_request_conditioner.sv
// rtl/emergency_request_conditioner.sv - debounce, hold and cooldown for the emergency request
// Purpose: turns the raw emergency request into a clean, rate-limited level
//          for the one-way traffic light controller.
// Ports:   clk       - system clock
//          reset     - asynchronous, active-high
//          req_in    - raw asynchronous request, active-high
//          cancel    - synchronous operator abort, active-high
//          emergency - conditioned request (high in ACTIVE or HOLD)
//          state_o   - current FSM state encoding
//          stuck     - sticky timeout flag
// Config:  EMERG_TIMEOUT_EN - limits time in ACTIVE and enables stuck;
//          when undefined stuck is tied 0 and TIMEOUT_TICKS is unused.
module emergency_request_conditioner
  import traffic_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       cancel,
  output logic       emergency,
  output logic [2:0] state_o,
  output logic       stuck
);

  localparam int MAX_DH  = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
  localparam int MAX_CT  = (COOLDOWN_TICKS > TIMEOUT_TICKS) ? COOLDOWN_TICKS : TIMEOUT_TICKS;
  localparam int MAX_ALL = (MAX_DH > MAX_CT) ? MAX_DH : MAX_CT;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  logic          sync_meta;
  logic          req_s;
  logic          tick;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          stuck_q;
`ifdef EMERG_TIMEOUT_EN
  logic          timeout_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      req_s     <= 1'b0;
    end else begin
      sync_meta <= req_in;
      req_s     <= sync_meta;
    end
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // cancel is tested first in every abortable state so it beats req_s and
  // tick; a req_s change is tested before tick so it wins without counting.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
`ifdef EMERG_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req_s && !stuck_q) state_n = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (cancel) state_n = ST_COOLDOWN;
        else if (!req_s) state_n = ST_IDLE;
        else if (tick) begin
          if (cnt == CW'(DEBOUNCE_TICKS - 1)) state_n = ST_ACTIVE;
          else cnt_n = cnt + CW'(1);
        end
      end
      ST_ACTIVE: begin
        if (cancel) state_n = ST_COOLDOWN;
        else if (!req_s) state_n = ST_HOLD;
`ifdef EMERG_TIMEOUT_EN
        else if (tick) begin
          if (cnt == CW'(TIMEOUT_TICKS - 1)) begin
            state_n     = ST_COOLDOWN;
            timeout_hit = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
`endif
      end
      ST_HOLD: begin
        if (cancel) state_n = ST_COOLDOWN;
        else if (req_s) state_n = ST_ACTIVE;
        else if (tick) begin
          if (cnt == CW'(HOLD_TICKS - 1)) state_n = ST_COOLDOWN;
          else cnt_n = cnt + CW'(1);
        end
      end
      ST_COOLDOWN: begin
        if (tick) begin
          if (cnt == CW'(COOLDOWN_TICKS - 1)) state_n = ST_IDLE;
          else cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // One counter serves every state, so it restarts on any transition.
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      emergency <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      // Decoded from next-state so emergency flips on the same edge as state.
      emergency <= (state_n == ST_ACTIVE) || (state_n == ST_HOLD);
    end
  end

`ifdef EMERG_TIMEOUT_EN
  // A timeout only happens with req_s high, so clear and set never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuck_q <= 1'b0;
    end else if (!req_s) begin
      stuck_q <= 1'b0;
    end else if (timeout_hit) begin
      stuck_q <= 1'b1;
    end
  end
`else
  assign stuck_q = 1'b0;
`endif

  assign stuck   = stuck_q;
  assign state_o = state;

endmodule

// File: tb/tb_emergency_request_conditioner.sv
// tb/tb_emergency_request_conditioner.sv - scoreboard bench for emergency_request_conditioner
module tb_emergency_request_conditioner;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 2;
  localparam int CT = 5;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in;
  logic       cancel;
  logic       emergency;
  logic [2:0] state_o;
  logic       stuck;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  emergency_request_conditioner #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB),
    .HOLD_TICKS    (HT),
    .COOLDOWN_TICKS(CT),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .cancel   (cancel),
    .emergency(emergency),
    .state_o  (state_o),
    .stuck    (stuck)
  );

  function automatic exp_t mk(input int lo, input int hi);
    exp_t r;
    r.lo = lo;
    r.hi = hi;
    return r;
  endfunction

  task automatic apply_reset();
    reset  = 1'b1;
    req_in = 1'b0;
    cancel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_emergency_high();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (emergency === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    integer obs;
    exp_t   e;
    int     lat;
    reset  = 1'b1;
    req_in = 1'b1;
    cancel = 1'b0;
    sb.push_back(mk(0, 0));
    sb.push_back(mk(0, 0));
    sb.push_back(mk(0, 0));
    repeat (3) @(negedge clk);
    e = sb.pop_front(); obs = emergency; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL reset_emergency: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL reset_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = stuck; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL reset_stuck: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    reset = 1'b0;
    // req_s rises on the 2nd edge after release; latency is counted from there.
    sb.push_back(mk((DB - 1) * TD + 1, DB * TD));
    sb.push_back(mk(2, 2));
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (emergency === 1'b1) begin
        lat = k - 2;
        break;
      end
    end
    e = sb.pop_front(); obs = lat; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL debounce_latency: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL active_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
  endtask

  task automatic test_glitch();
    integer obs;
    exp_t   e;
    int     mx;
    int     em;
    apply_reset();
    sb.push_back(mk(1, 1));
    sb.push_back(mk(0, 0));
    mx = 0;
    em = 0;
    for (int p = 0; p < 8; p++) begin
      req_in = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (int'(state_o) > mx) mx = int'(state_o);
        if (emergency !== 1'b0) em = 1;
      end
      req_in = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (int'(state_o) > mx) mx = int'(state_o);
        if (emergency !== 1'b0) em = 1;
      end
    end
    e = sb.pop_front(); obs = mx; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL glitch_max_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = em; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL glitch_emergency: got %0d want %0d..%0d", obs, e.lo, e.hi); end
  endtask

  task automatic test_hold_release();
    integer obs;
    exp_t   e;
    int     hk;
    int     fk;
    int     cl;
    int     odd;
    apply_reset();
    req_in = 1'b1;
    sb.push_back(mk(2, 2));
    repeat (40) @(negedge clk);
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL held_active: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    req_in = 1'b0;
    // req_s falls on edge 2; HOLD one clk later.
    sb.push_back(mk(3, 3));
    sb.push_back(mk(HT * TD - TD + 1, HT * TD));
    sb.push_back(mk(CT * TD - TD + 1, CT * TD));
    sb.push_back(mk(0, 0));
    sb.push_back(mk(0, 0));
    hk = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (state_o === 3'd3) begin hk = k; break; end
    end
    e = sb.pop_front(); obs = hk; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL hold_entry: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    fk = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (emergency === 1'b0) begin fk = k; break; end
    end
    e = sb.pop_front(); obs = fk; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL hold_length: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    cl  = -1;
    odd = 0;
    for (int j = 1; j <= 30; j++) begin
      if (j == 3) req_in = 1'b1;
      if (j == 7) req_in = 1'b0;
      @(negedge clk);
      if (state_o === 3'd0) begin cl = j; break; end
      else if (state_o !== 3'd4) odd = 1;
    end
    e = sb.pop_front(); obs = cl; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL cooldown_length: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = odd; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL cooldown_ignores_req: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    repeat (6) @(negedge clk);
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL idle_after_cooldown: got %0d want %0d..%0d", obs, e.lo, e.hi); end
  endtask

  task automatic test_retrigger();
    integer obs;
    exp_t   e;
    int     sawh;
    int     low;
    apply_reset();
    req_in = 1'b1;
    wait_emergency_high();
    sb.push_back(mk(1, 1));
    sb.push_back(mk(0, 0));
    sb.push_back(mk(2, 2));
    sawh = 0;
    low  = 0;
    req_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (state_o === 3'd3) sawh = 1;
      if (emergency !== 1'b1) low = 1;
    end
    req_in = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (state_o === 3'd3) sawh = 1;
      if (emergency !== 1'b1) low = 1;
    end
    e = sb.pop_front(); obs = sawh; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL retrigger_hold_seen: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = low; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL retrigger_emergency_drop: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL retrigger_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
  endtask

  task automatic test_cancel();
    integer obs;
    exp_t   e;
    apply_reset();
    req_in = 1'b1;
    wait_emergency_high();
    sb.push_back(mk(0, 0));
    sb.push_back(mk(4, 4));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    e = sb.pop_front(); obs = emergency; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL cancel_emergency: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL cancel_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    apply_reset();
    sb.push_back(mk(0, 0));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL cancel_in_idle: got %0d want %0d..%0d", obs, e.lo, e.hi); end
  endtask

  task automatic test_timeout();
    integer obs;
    exp_t   e;
`ifdef EMERG_TIMEOUT_EN
    int d;
    int mx;
    int got;
    apply_reset();
    req_in = 1'b1;
    wait_emergency_high();
    sb.push_back(mk((TO - 1) * TD + 1, TO * TD));
    sb.push_back(mk(1, 1));
    d = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (state_o === 3'd4) begin d = k; break; end
    end
    e = sb.pop_front(); obs = d; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL timeout_length: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = stuck; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL stuck_set: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (state_o === 3'd0) break;
    end
    sb.push_back(mk(0, 0));
    sb.push_back(mk(1, 1));
    mx = 0;
    repeat (12) begin
      @(negedge clk);
      if (int'(state_o) > mx) mx = int'(state_o);
    end
    e = sb.pop_front(); obs = mx; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL stuck_blocks_debounce: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = stuck; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL stuck_sticky: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    req_in = 1'b0;
    sb.push_back(mk(0, 0));
    repeat (3) @(negedge clk);
    e = sb.pop_front(); obs = stuck; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL stuck_clear: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    req_in = 1'b1;
    sb.push_back(mk(1, 1));
    got = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (state_o === 3'd1) begin got = 1; break; end
    end
    e = sb.pop_front(); obs = got; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL redebounce_after_clear: got %0d want %0d..%0d", obs, e.lo, e.hi); end
`else
    int low;
    apply_reset();
    req_in = 1'b1;
    wait_emergency_high();
    sb.push_back(mk(0, 0));
    sb.push_back(mk(2, 2));
    low = 0;
    repeat (100 * TD) begin
      @(negedge clk);
      if (emergency !== 1'b1 || stuck !== 1'b0) low = 1;
    end
    e = sb.pop_front(); obs = low; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL no_timeout_hold: got %0d want %0d..%0d", obs, e.lo, e.hi); end
    e = sb.pop_front(); obs = state_o; total++;
    if ((obs >= e.lo && obs <= e.hi) !== 1'b1) begin bad++; $display("FAIL no_timeout_state: got %0d want %0d..%0d", obs, e.lo, e.hi); end
`endif
  endtask

  initial begin
    reset  = 1'b1;
    req_in = 1'b0;
    cancel = 1'b0;
    test_reset();
    test_glitch();
    test_hold_release();
    test_retrigger();
    test_cancel();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
